// File: rtl/bitcnt_arbiter_if.sv
// Request/response bundle between NREQ clients and the shared bitcnt arbiter.
interface bitcnt_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [64*NREQ-1:0] req_data;
  logic [3*NREQ-1:0]  req_func;
  logic               resp_valid;
  logic               resp_ready;
  logic [63:0]        resp_data;
  logic [IDW-1:0]     resp_id;
  logic               resp_err;
  logic [31:0]        accept_cnt;

  // Client / consumer side
  modport master (
    output req_valid, req_data, req_func, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_err, accept_cnt
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, req_func, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_err, accept_cnt
  );
endinterface

// File: rtl/bitcnt_arbiter.sv
// Round-robin arbiter sharing one CLZ/CTZ/PCNT unit between NREQ requesters.
// One-entry registered response slot tagged with the requester id.
// Reset is synchronous and active-high.
module bitcnt_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input logic              clock,
  input logic              reset,
  bitcnt_arbiter_if.slave  bus
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned PW  = IDW + 1;

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_found;
  logic            accept;
  logic            xfer;
  logic [NREQ-1:0] ready;
  logic [PW-1:0]   scan_pos;
  logic [IDW-1:0]  scan_idx;

  logic [63:0]     op;
  logic [2:0]      fn;
  logic [6:0]      clz64, clz32, ctz64, ctz32, pcnt64, pcnt32;
  logic [63:0]     result;
  logic            result_err;

  logic            slot_valid;
  logic [63:0]     slot_data;
  logic [IDW-1:0]  slot_id;
  logic            slot_err;
  logic [31:0]     acc_cnt;

  // Pick the first valid requester starting at rr_ptr, wrapping at NREQ
  always_comb begin
    accept    = !slot_valid || bus.resp_ready;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_pos  = '0;
    scan_idx  = '0;
    ready     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_pos = PW'(rr_ptr) + PW'(k);
      if (scan_pos >= PW'(NREQ)) scan_pos = scan_pos - PW'(NREQ);
      scan_idx = scan_pos[IDW-1:0];
      if (!gnt_found && bus.req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    xfer = accept && !reset && gnt_found;
    if (xfer) ready[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = ready;

  // Operand and function of the granted requester
  always_comb begin
    op = '0;
    fn = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        op = bus.req_data[64*i +: 64];
        fn = bus.req_func[3*i +: 3];
      end
    end
  end

  // Bit counts; the highest/lowest set bit wins by loop order
  always_comb begin
    clz64  = 7'd64;
    clz32  = 7'd32;
    ctz64  = 7'd64;
    ctz32  = 7'd32;
    pcnt64 = '0;
    pcnt32 = '0;
    for (int i = 0; i < 64; i++) begin
      if (op[i]) clz64 = 7'(63 - i);
      pcnt64 = pcnt64 + 7'(op[i]);
    end
    for (int i = 0; i < 32; i++) begin
      if (op[i]) clz32 = 7'(31 - i);
      pcnt32 = pcnt32 + 7'(op[i]);
    end
    for (int i = 63; i >= 0; i--) begin
      if (op[i]) ctz64 = 7'(i);
    end
    for (int i = 31; i >= 0; i--) begin
      if (op[i]) ctz32 = 7'(i);
    end
  end

  // Function select; codes 110/111 yield zero with the error flag
  always_comb begin
    result     = '0;
    result_err = 1'b0;
    case (fn)
      3'b000:  result = 64'(clz64);
      3'b001:  result = 64'(clz32);
      3'b010:  result = 64'(ctz64);
      3'b011:  result = 64'(ctz32);
      3'b100:  result = 64'(pcnt64);
      3'b101:  result = 64'(pcnt32);
      default: result_err = 1'b1;
    endcase
  end

  // Response slot, round-robin pointer and accept counter
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid <= 1'b0;
      slot_data  <= '0;
      slot_id    <= '0;
      slot_err   <= 1'b0;
      acc_cnt    <= '0;
      rr_ptr     <= '0;
    end else if (xfer) begin
      slot_valid <= 1'b1;
      slot_data  <= result;
      slot_id    <= gnt_idx;
      slot_err   <= result_err;
      acc_cnt    <= acc_cnt + 32'd1;
      rr_ptr     <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end else if (bus.resp_ready) begin
      slot_valid <= 1'b0;
    end
  end

  assign bus.resp_valid = slot_valid;
  assign bus.resp_data  = slot_data;
  assign bus.resp_id    = slot_id;
  assign bus.resp_err   = slot_err;
  assign bus.accept_cnt = acc_cnt;
endmodule

// File: tb/tb_bitcnt_arbiter.sv
// Self-checking bench for bitcnt_arbiter: directed steps plus random traffic
// compared against a behavioural reference model.
module tb_bitcnt_arbiter;
  localparam int unsigned NREQ = 4;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  bitcnt_arbiter_if #(.NREQ(NREQ)) bus ();

  bitcnt_arbiter #(.NREQ(NREQ)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference model state
  int          m_rr;
  bit          m_valid;
  logic [63:0] m_data;
  int          m_id;
  bit          m_err;
  logic [31:0] m_cnt;

  logic [63:0] saved_data;
  logic [63:0] saved_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_f(input logic [63:0] d, input logic [2:0] f);
    int          w;
    int          n;
    logic [63:0] x;
    w = f[0] ? 32 : 64;
    x = f[0] ? {32'd0, d[31:0]} : d;
    n = 0;
    case (f)
      3'd0, 3'd1: begin
        while (n < w && x[w-1-n] == 1'b0) n++;
        return 64'(n);
      end
      3'd2, 3'd3: begin
        while (n < w && x[n] == 1'b0) n++;
        return 64'(n);
      end
      3'd4, 3'd5: return 64'($countones(x));
      default:    return 64'd0;
    endcase
  endfunction

  function automatic int ref_grant();
    int i;
    if (reset) return -1;
    if (m_valid && !bus.resp_ready) return -1;
    for (int k = 0; k < int'(NREQ); k++) begin
      i = (m_rr + k) % int'(NREQ);
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock: check req_ready, advance model, check registered outputs
  task automatic tick();
    int              g;
    logic [NREQ-1:0] exp_ready;
    logic [2:0]      f;
    #1;
    g = ref_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    @(posedge clock);
    if (reset) begin
      m_rr = 0; m_valid = 0; m_data = '0; m_id = 0; m_err = 0; m_cnt = '0;
    end else if (g >= 0) begin
      f       = bus.req_func[3*g +: 3];
      m_valid = 1;
      m_data  = ref_f(bus.req_data[64*g +: 64], f);
      m_err   = (f >= 3'd6);
      m_id    = g;
      m_rr    = (g + 1) % int'(NREQ);
      m_cnt   = m_cnt + 32'd1;
    end else if (bus.resp_ready) begin
      m_valid = 0;
    end
    #1;
    chk("resp_valid", 64'(bus.resp_valid), 64'(m_valid));
    chk("accept_cnt", 64'(bus.accept_cnt), 64'(m_cnt));
    if (m_valid) begin
      chk("resp_data", bus.resp_data, m_data);
      chk("resp_id", 64'(bus.resp_id), 64'(m_id));
      chk("resp_err", 64'(bus.resp_err), 64'(m_err));
    end
  endtask

  task automatic set_req(input int i, input logic [63:0] d, input logic [2:0] f);
    bus.req_data[64*i +: 64] = d;
    bus.req_func[3*i +: 3]   = f;
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 64'd0;
      2:       return ~64'd0;
      default: return 64'd1 << $urandom_range(0, 63);
    endcase
  endfunction

  initial begin
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_func   = '0;
    bus.resp_ready = 1'b0;
    m_rr = 0; m_valid = 0; m_data = '0; m_id = 0; m_err = 0; m_cnt = '0;

    // Reset state
    tick();
    tick();
    chk("rst_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_data", bus.resp_data, 64'd0);
    chk("rst_id", 64'(bus.resp_id), 64'd0);
    chk("rst_err", 64'(bus.resp_err), 64'd0);
    chk("rst_cnt", 64'(bus.accept_cnt), 64'd0);

    // Single op: clz64 of 0xF0 from port 0
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    set_req(0, 64'h0000_0000_0000_00F0, 3'b000);
    bus.req_valid = 4'b0001;
    tick();
    chk("t1_valid", 64'(bus.resp_valid), 64'd1);
    chk("t1_data", bus.resp_data, 64'd56);
    chk("t1_id", 64'(bus.resp_id), 64'd0);
    chk("t1_err", 64'(bus.resp_err), 64'd0);
    bus.req_valid = '0;
    tick();

    // Round-robin from reset with all requesters valid
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 64'(i + 1) << (8 * i), 3'($urandom_range(0, 5)));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t2_id", 64'(bus.resp_id), 64'(k % 4));
      chk("t2_cnt", 64'(bus.accept_cnt), 64'(k + 1));
    end

    // Backpressure: slot full, consumer stalls three cycles
    bus.resp_ready = 1'b0;
    tick();
    saved_data = bus.resp_data;
    saved_id   = 64'(bus.resp_id);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("t3_hold_data", bus.resp_data, saved_data);
      chk("t3_hold_id", 64'(bus.resp_id), saved_id);
      chk("t3_ready0", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("t3_nobubble", 64'(bus.resp_valid), 64'd1);
    chk("t3_next_id", 64'(bus.resp_id), (saved_id + 64'd1) % 64'd4);

    // Boundary operands from port 1
    bus.req_valid = 4'b0010;
    set_req(1, 64'hFFFF_FFFF_0000_0000, 3'b011);
    tick();
    chk("t4_ctz32", bus.resp_data, 64'd32);
    set_req(1, 64'd0, 3'b000);
    tick();
    chk("t4_clz64", bus.resp_data, 64'd64);
    set_req(1, ~64'd0, 3'b100);
    tick();
    chk("t4_pcnt64", bus.resp_data, 64'd64);
    set_req(1, 64'hFFFF_FFFF_0000_000F, 3'b101);
    tick();
    chk("t4_pcnt32", bus.resp_data, 64'd4);

    // Illegal function from port 2; pointer then moves to 3
    bus.req_valid = 4'b0100;
    set_req(2, 64'h1234_5678_9ABC_DEF0, 3'b110);
    tick();
    chk("t5_data", bus.resp_data, 64'd0);
    chk("t5_err", 64'(bus.resp_err), 64'd1);
    chk("t5_id", 64'(bus.resp_id), 64'd2);
    for (int i = 0; i < 4; i++) set_req(i, 64'hFF, 3'b100);
    bus.req_valid = 4'b1111;
    tick();
    chk("t5_rr", 64'(bus.resp_id), 64'd3);
    chk("t5_err_clear", 64'(bus.resp_err), 64'd0);

    // Reset while the slot is held
    bus.resp_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("t6_valid", 64'(bus.resp_valid), 64'd0);
    chk("t6_cnt", 64'(bus.accept_cnt), 64'd0);
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    bus.req_valid = 4'b1010;
    tick();
    chk("t6_first", 64'(bus.resp_id), 64'd1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      bus.req_valid  = 4'($urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) set_req(i, rand_operand(), 3'($urandom));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
